// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   state_e            - ownership FSM states (IDLE, OWN0, OWN1)
//   REQ_CPU / REQ_AUX  - requester indices (CPU load/store path, secondary master)
//   DEFAULT_ADDR_W     - default word-index width
//   DEFAULT_MAX_HOLD   - default cap on locked grants while the other side waits
//   onehot2()          - requester index to one-hot grant vector
package dmem_arb_pkg;

  localparam int DEFAULT_ADDR_W   = 8;
  localparam int DEFAULT_MAX_HOLD = 4;

  localparam int REQ_CPU = 0;
  localparam int REQ_AUX = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and memory-side signals of the arbiter.
//   Requester side: req_i, we_i, lock_i, addr0_i/addr1_i, wdata0_i/wdata1_i in;
//                   gnt_o, rvalid_o, rdata_o, err_o out.
//   Memory side:    mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o out; mem_rdata_i in.
//   Modport slave is the arbiter's view, master is the environment's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = dmem_arb_pkg::DEFAULT_ADDR_W
);
  logic [1:0]        req_i;
  logic [1:0]        we_i;
  logic [1:0]        lock_i;
  logic [31:0]       addr0_i;
  logic [31:0]       addr1_i;
  logic [31:0]       wdata0_i;
  logic [31:0]       wdata1_i;
  logic [1:0]        gnt_o;
  logic [1:0]        rvalid_o;
  logic [31:0]       rdata_o;
  logic [1:0]        err_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic              mem_re_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o, mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o
  );

  modport master (
    output req_i, we_i, lock_i, addr0_i, addr1_i, wdata0_i, wdata1_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   req[1:0] in  - request per side
//   rr       in  - preferred side when both request
//   gnt[1:0] out - one-hot grant, or zero with no request
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) gnt = onehot2(rr);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data memory between the CPU (requester 0)
// and a secondary master (requester 1). One access per cycle, read data
// registered one cycle after the grant, bounded locked bursts.
//   clk  in - clock, rising edge
//   rst  in - synchronous active-high reset
//   bus     - dmem_arbiter_if.slave: requests, grants, completions, memory port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [1:0]        pick_gnt;
  logic [1:0]        gnt;
  logic              granted;
  logic              owner;      // index of the granted side, meaningful when granted
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic              sel_we;
  logic              sel_lock;
  logic              other_req;
  logic              in_range;
  logic              rd_fire;
  logic [HOLD_W-1:0] hold_inc;
  logic              unused_addr_lsbs;

  rr_pick2 u_pick (
    .req (bus.req_i),
    .rr  (rr_q),
    .gnt (pick_gnt)
  );

  // Grant: round-robin when nobody owns the memory, owner-only under lock.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    gnt = '0;
    unique case (state_q)
      IDLE:    gnt = pick_gnt;
      OWN0:    gnt = bus.req_i[REQ_CPU] ? onehot2(1'b0) : 2'b00;
      OWN1:    gnt = bus.req_i[REQ_AUX] ? onehot2(1'b1) : 2'b00;
      default: gnt = '0;
    endcase
    if (rst) gnt = '0;
  end

  assign granted          = |gnt;
  assign owner            = gnt[REQ_AUX];
  assign sel_addr         = owner ? bus.addr1_i  : bus.addr0_i;
  assign sel_wdata        = owner ? bus.wdata1_i : bus.wdata0_i;
  assign sel_we           = bus.we_i[owner];
  assign sel_lock         = bus.lock_i[owner];
  assign other_req        = bus.req_i[~owner];
  assign in_range         = (sel_addr[31:ADDR_W+2] == '0);
  assign rd_fire          = granted & ~sel_we;
  assign hold_inc         = hold_q + HOLD_W'(1);
  assign unused_addr_lsbs = ^sel_addr[1:0];

  // Ownership FSM, round-robin pointer and hold counter. The hold counter
  // counts locked grants while the other side waits, including the grant that
  // takes the lock, so MAX_HOLD bounds the waiter's delay exactly.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    if (granted) begin
      if (state_q == IDLE && (&bus.req_i)) rr_d = ~owner;
      if (!sel_lock) begin
        state_d = IDLE;
        hold_d  = '0;
      end else if (other_req) begin
        if (hold_inc >= HOLD_W'(MAX_HOLD)) begin
          // Cap reached: release and hand the next contested slot to the waiter.
          state_d = IDLE;
          hold_d  = '0;
          rr_d    = ~owner;
        end else begin
          state_d = owner ? OWN1 : OWN0;
          hold_d  = hold_inc;
        end
      end else begin
        state_d = owner ? OWN1 : OWN0;
      end
    end else begin
      // No grant: either nobody asked, or the owner dropped its request.
      state_d = IDLE;
      hold_d  = '0;
    end
  end

  // Completion registers. Out-of-range accesses are granted but never reach
  // the memory; reads among them complete with zero data and an error.
  always_comb begin
    rvalid_d = rd_fire ? gnt : 2'b00;
    err_d    = (granted && !in_range) ? gnt : 2'b00;
    rdata_d  = rdata_q;
    if (rd_fire) rdata_d = in_range ? bus.mem_rdata_i : 32'h0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= 1'b0;
      hold_q   <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      hold_q   <= hold_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Completions are masked while reset is held so an in-flight read that
  // meets reset is never reported.
  assign bus.gnt_o       = gnt;
  assign bus.rvalid_o    = rst ? 2'b00 : rvalid_q;
  assign bus.err_o       = rst ? 2'b00 : err_q;
  assign bus.rdata_o     = rst ? 32'h0 : rdata_q;
  assign bus.mem_addr_o  = sel_addr[ADDR_W+1:2];
  assign bus.mem_we_o    = granted & sel_we & in_range;
  assign bus.mem_re_o    = rd_fire & in_range;
  assign bus.mem_wdata_o = sel_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// traffic. A reference model predicts grants and memory strobes each cycle and
// queues expected completions; a monitor pops and compares them.
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W   = 8;
  localparam int MAX_HOLD = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory attached to the arbiter; preload port is used only during reset.
  logic [31:0]       mem [DEPTH];
  logic              pl_en   = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [31:0]       pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (bus.mem_we_o) mem[bus.mem_addr_o] <= bus.mem_wdata_o;
  end
  assign bus.mem_rdata_i = mem[bus.mem_addr_o];

  // Reference model state: memory image, current lock owner (-1 = none),
  // preferred side for the next tie, grants taken while the other side waited.
  logic [31:0] ref_mem [DEPTH];
  int m_owner = -1;
  int m_rr    = 0;
  int m_waits = 0;

  typedef struct {
    int          due;
    logic [1:0]  rv;
    logic [1:0]  er;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic model_step();
    int          w;
    int          word;
    logic [31:0] a;
    logic [31:0] d;
    bit          wr;
    bit          inr;
    exp_t        e;
    if (rst) begin
      check("gnt_in_reset", {30'h0, bus.gnt_o}, 32'h0);
      m_owner = -1;
      m_rr    = 0;
      m_waits = 0;
      return;
    end
    w = -1;
    if (m_owner >= 0) begin
      if (bus.req_i[m_owner]) w = m_owner;
    end else if (bus.req_i == 2'b11) begin
      w    = m_rr;
      m_rr = 1 - w;
    end else if (bus.req_i[0]) begin
      w = 0;
    end else if (bus.req_i[1]) begin
      w = 1;
    end
    check("gnt", {30'h0, bus.gnt_o}, (w < 0) ? 32'h0 : 32'(1 << w));
    if (w < 0) begin
      check("mem_en_idle", {30'h0, bus.mem_we_o, bus.mem_re_o}, 32'h0);
      m_owner = -1;
      m_waits = 0;
      return;
    end
    a    = (w == 1) ? bus.addr1_i : bus.addr0_i;
    d    = (w == 1) ? bus.wdata1_i : bus.wdata0_i;
    wr   = bus.we_i[w];
    inr  = (a / 4) < DEPTH;
    word = int'((a / 4) % DEPTH);
    check("mem_en", {30'h0, bus.mem_we_o, bus.mem_re_o}, {30'h0, wr & inr, ~wr & inr});
    if (inr) check("mem_addr", {24'h0, bus.mem_addr_o}, 32'(word));
    if (wr && inr) begin
      check("mem_wdata", bus.mem_wdata_o, d);
      ref_mem[word] = d;
    end
    if (!inr || !wr) begin
      e.due = cyc + 1;
      e.rv  = wr ? 2'b00 : 2'(1 << w);
      e.er  = inr ? 2'b00 : 2'(1 << w);
      e.rd  = (!wr && inr) ? ref_mem[word] : 32'h0;
      sb.push_back(e);
    end
    if (!bus.lock_i[w]) begin
      m_owner = -1;
      m_waits = 0;
    end else if (bus.req_i[1-w]) begin
      m_waits++;
      if (m_waits >= MAX_HOLD) begin
        m_owner = -1;
        m_waits = 0;
        m_rr    = 1 - w;
      end else begin
        m_owner = w;
      end
    end else begin
      m_owner = w;
    end
  endtask

  // Drive one cycle shortly after the rising edge, check at the falling edge.
  task automatic tick(input logic r, input logic [1:0] req, input logic [1:0] we,
                      input logic [1:0] lock, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1);
    @(posedge clk);
    #1;
    rst          = r;
    bus.req_i    = req;
    bus.we_i     = we;
    bus.lock_i   = lock;
    bus.addr0_i  = a0;
    bus.addr1_i  = a1;
    bus.wdata0_i = d0;
    bus.wdata1_i = d1;
    @(negedge clk);
    model_step();
  endtask

  task automatic idle();
    tick(1'b0, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 15) == 0)
      return (32'h1 << $urandom_range(ADDR_W + 2, 31)) | ($urandom & 32'h3FF);
    return $urandom & 32'h3FF;
  endfunction

  // Completion monitor.
  always @(negedge clk) begin : monitor
    exp_t e;
    logic have;
    have = 1'b0;
    e    = '{due: 0, rv: 2'b00, er: 2'b00, rd: 32'h0};
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e    = sb.pop_front();
      have = 1'b1;
    end
    if (rst) begin
      check("rvalid_in_reset", {30'h0, bus.rvalid_o}, 32'h0);
      check("err_in_reset", {30'h0, bus.err_o}, 32'h0);
      check("rdata_in_reset", bus.rdata_o, 32'h0);
    end else if (have || bus.rvalid_o != 2'b00 || bus.err_o != 2'b00) begin
      check("rvalid", {30'h0, bus.rvalid_o}, {30'h0, e.rv});
      check("err", {30'h0, bus.err_o}, {30'h0, e.er});
      if (e.rv != 2'b00) check("rdata", bus.rdata_o, e.rd);
    end
  end

  logic [1:0] cont_exp [4];
  logic [1:0] lc_exp   [10];

  initial begin
    bus.req_i    = '0;
    bus.we_i     = '0;
    bus.lock_i   = '0;
    bus.addr0_i  = '0;
    bus.addr1_i  = '0;
    bus.wdata0_i = '0;
    bus.wdata1_i = '0;
    cont_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    lc_exp   = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

    // Preload the memory under reset; word 5 holds a known pattern.
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk);
      #1;
      pl_en      = 1'b1;
      pl_addr    = ADDR_W'(i);
      pl_data    = (i == 5) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = pl_data;
    end
    @(posedge clk);
    #1;
    pl_en = 1'b0;

    // Reset state, with requests held high.
    tick(1'b1, 2'b11, 2'b00, 2'b00, 32'h14, 32'h14, 32'h0, 32'h0);
    tick(1'b1, 2'b11, 2'b00, 2'b00, 32'h14, 32'h14, 32'h0, 32'h0);
    check("reset_gnt", {30'h0, bus.gnt_o}, 32'h0);
    check("reset_rvalid", {30'h0, bus.rvalid_o}, 32'h0);
    check("reset_err", {30'h0, bus.err_o}, 32'h0);
    check("reset_rdata", bus.rdata_o, 32'h0);

    // Single read of word 5.
    tick(1'b0, 2'b01, 2'b00, 2'b00, 32'h14, 32'h0, 32'h0, 32'h0);
    check("single_gnt", {30'h0, bus.gnt_o}, 32'h1);
    check("single_mem_re", {31'h0, bus.mem_re_o}, 32'h1);
    idle();
    check("single_rvalid", {30'h0, bus.rvalid_o}, 32'h1);
    check("single_rdata", bus.rdata_o, 32'hDEADBEEF);

    // Contention without lock alternates, requester 0 first.
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 2'b11, 2'b00, 2'b00, $urandom & 32'h3FC, $urandom & 32'h3FC, 32'h0, 32'h0);
      check("contend_gnt", {30'h0, bus.gnt_o}, {30'h0, cont_exp[k]});
    end

    // Lock cap: one tie first so requester 1 wins the next tie.
    tick(1'b0, 2'b11, 2'b00, 2'b00, 32'h80, 32'h80, 32'h0, 32'h0);
    check("lockcap_pre_gnt", {30'h0, bus.gnt_o}, 32'h1);
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 2'b11, 2'b10, 2'b10, 32'h80, 32'h40 + 32'(4 * k), 32'h0, 32'hC0DE0000 + 32'(k));
      check("lockcap_gnt", {30'h0, bus.gnt_o}, {30'h0, lc_exp[k]});
    end
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, (i < 4) ? 2'b01 : 2'b00, 2'b00, 2'b00, 32'h40 + 32'(4 * i), 32'h0, 32'h0, 32'h0);
      if (i > 0) check("lockcap_mem", bus.rdata_o, 32'hC0DE0000 + 32'(i - 1));
    end

    // Read-after-write in consecutive cycles.
    tick(1'b0, 2'b01, 2'b01, 2'b00, 32'h20, 32'h0, 32'h12345678, 32'h0);
    tick(1'b0, 2'b01, 2'b00, 2'b00, 32'h20, 32'h0, 32'h0, 32'h0);
    idle();
    check("raw_rvalid", {30'h0, bus.rvalid_o}, 32'h1);
    check("raw_rdata", bus.rdata_o, 32'h12345678);

    // Out-of-range read.
    tick(1'b0, 2'b10, 2'b00, 2'b00, 32'h0, 32'h1000, 32'h0, 32'h0);
    check("oor_gnt", {30'h0, bus.gnt_o}, 32'h2);
    check("oor_mem_re", {31'h0, bus.mem_re_o}, 32'h0);
    idle();
    check("oor_err", {30'h0, bus.err_o}, 32'h2);
    check("oor_rvalid", {30'h0, bus.rvalid_o}, 32'h2);
    check("oor_rdata", bus.rdata_o, 32'h0);

    // Reset right after a locked read grant.
    tick(1'b0, 2'b10, 2'b00, 2'b10, 32'h0, 32'h14, 32'h0, 32'h0);
    check("rstmid_gnt", {30'h0, bus.gnt_o}, 32'h2);
    tick(1'b1, 2'b11, 2'b00, 2'b00, 32'h14, 32'h14, 32'h0, 32'h0);
    check("rstmid_gnt_rst", {30'h0, bus.gnt_o}, 32'h0);
    check("rstmid_rvalid", {30'h0, bus.rvalid_o}, 32'h0);
    check("rstmid_err", {30'h0, bus.err_o}, 32'h0);
    check("rstmid_rdata", bus.rdata_o, 32'h0);
    tick(1'b0, 2'b11, 2'b00, 2'b00, 32'h14, 32'h14, 32'h0, 32'h0);
    check("rstmid_post_gnt", {30'h0, bus.gnt_o}, 32'h1);
    idle();
    check("rstmid_post_rdata", bus.rdata_o, 32'hDEADBEEF);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      logic       r;
      logic [1:0] rq;
      logic [1:0] lk;
      r  = ($urandom_range(0, 299) == 0);
      rq = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      lk = {($urandom_range(0, 1) == 0), ($urandom_range(0, 2) == 0)};
      tick(r, rq, 2'($urandom), lk, rand_addr(), rand_addr(), $urandom, $urandom);
    end

    idle();
    idle();
    check("sb_drain", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-port data memory. It shares the memory between the CPU load/store path (requester 0) and a secondary master such as a program loader or debug port (requester 1). It issues at most one access per cycle, returns read data registered one cycle later, and supports bounded locked bursts. It sits between the requesters and the data memory's address, write-enable, read-enable and data ports.

## Interface
- `ADDR_W`, default 8: word-index width; memory depth is 2**ADDR_W words.
- `MAX_HOLD`, default 4: maximum consecutive granted cycles under lock while the other requester waits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_i[1:0]` in 2: access request per requester.
- `we_i[1:0]` in 2: 1 = write, 0 = read, per requester.
- `lock_i[1:0]` in 2: keep ownership after this access.
- `addr0_i`, `addr1_i` in 32: byte addresses; `[1:0]` are ignored.
- `wdata0_i`, `wdata1_i` in 32: write data.
- `gnt_o[1:0]` out 2: combinational grant, one-hot or zero.
- `rvalid_o[1:0]` out 2: read data valid, one cycle after a granted read.
- `rdata_o` out 32: registered read data, shared by both requesters.
- `err_o[1:0]` out 2: pulses with completion when the address is out of range.
- `mem_addr_o` out ADDR_W: word index, `addr[ADDR_W+1:2]` of the granted requester.
- `mem_we_o` out 1: memory write enable.
- `mem_re_o` out 1: memory read enable.
- `mem_wdata_o` out 32: memory write data.
- `mem_rdata_i` in 32: combinational memory read data.

## Operation
- FSM states:
  - IDLE: no owner.
  - OWN0: requester 0 holds a lock.
  - OWN1: requester 1 holds a lock.
- Grant in IDLE:
  - Single requester: that requester is granted.
  - Both requesting: grant goes to the side selected by the round-robin pointer `rr`. After such a contested grant, `rr` points to the other side.
- Grant in OWNx:
  - Requester x is granted while it asserts `req_i[x]`.
  - Requester x drops `req_i[x]` or `lock_i[x]`: return to IDLE next cycle.
  - A granted cycle with `lock_i[x]=1` in IDLE moves the FSM to OWNx.
- Hold counter:
  - Increments each granted cycle in OWNx while the other requester is requesting.
  - At `MAX_HOLD`, the FSM is forced to IDLE with `rr` pointing to the other side, even if lock is still asserted.
  - Clears on entering IDLE.
- Memory drive: the granted requester drives `mem_*`. `mem_we_o = we`, `mem_re_o = ~we`. All `mem_*` enables are 0 with no grant.
- Range check: an address with nonzero `addr[31:ADDR_W+2]` still counts as granted, but:
  - Both `mem_we_o` and `mem_re_o` are suppressed.
  - `err_o[x]` pulses next cycle.
  - For a read, `rvalid_o[x]` also pulses, with `rdata_o = 0`.
- Writes complete at grant. `rvalid_o` stays 0 for writes.

## Timing
- Cycle N: `req` is sampled and `gnt_o` is asserted combinationally. The memory write occurs within cycle N, with the write committed by the end of cycle N.
- Read data: `rdata_o` is registered on the rising edge ending cycle N. `rvalid_o[x]` is high for exactly cycle N+1.
- Throughput: one access per cycle. Back-to-back reads from the same owner stream with 1-cycle latency.
- Read-after-write to the same address in consecutive cycles returns the new data.
- Reset values:
  - `gnt_o=0`, `rvalid_o=0`, `err_o=0`, `rdata_o=0`.
  - FSM in IDLE, `rr` pointing to requester 0, hold counter 0.
- Reset during an outstanding read: the pending `rvalid` is discarded and no completion is emitted.
- Requests asserted during reset are not granted until the cycle after `rst` deasserts.
- Simultaneous requests in the cycle a lock is forced off: the other side wins the next arbitration.

## Structure
- Package `dmem_arb_pkg`:
  - FSM state enum (IDLE, OWN0, OWN1).
  - Requester index constants `REQ_CPU=0` and `REQ_AUX=1`.
  - Default `ADDR_W` and `MAX_HOLD`.
- Sub-module `rr_pick2`: combinational two-way round-robin picker taking `req[1:0]` and `rr`, producing a one-hot grant.
- The FSM, hold counter, response registers and mem mux live in the top module.

## Test plan
- **Single read:** reset, preload word 5 = 0xDEADBEEF, req0 read addr 0x14 → `gnt_o=01` in N, `rvalid_o=01` with `rdata_o=0xDEADBEEF` in N+1.
- **Contention:** both requesters read every cycle, no lock → grants alternate 01, 10, 01, 10, starting with requester 0 after reset.
- **Lock cap:** req1 writes with lock for 10 cycles while req0 waits (`MAX_HOLD=4`) → req1 is granted 4 cycles, then req0 is granted. Memory holds all 4 writes.
- **Read-after-write:** req0 writes 0x12345678 to 0x20, then reads 0x20 next cycle → `rdata_o=0x12345678`.
- **Out of range:** req1 read at 0x0000_1000 (`ADDR_W=8`) → `mem_re_o=0`, and next cycle `err_o=10`, `rvalid_o=10`, `rdata_o=0`.
- **Reset mid-read:** grant a read, assert `rst` on the next edge → no `rvalid`, all outputs 0, FSM in IDLE.
